// File: rtl/alu_seq.sv
// Registered, parametrised ALU with valid/ready handshakes and an iterative
// shift-add multiplier for MUL/MULHU.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Output,
    output logic             CarryOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy,
    output logic             state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and data is held while valid && !ready.

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    localparam logic [3:0] OP_NOR   = 4'd0;
    localparam logic [3:0] OP_SLT   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state, state_next;

    logic accept, is_mul_op, mul_start, mul_done;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] add_b;
    logic             add_sub, add_ovf;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;

    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_addend, mul_res;
    logic [SW-1:0]      cnt;
    logic               mul_hi;

    assign is_mul_op = MUL_EN && ((ALUControl == OP_MUL) || (ALUControl == OP_MULHU));
    assign busy      = (state == S_MUL);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        mul_start  = 1'b0;
        mul_done   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept && is_mul_op) begin
                    mul_start  = 1'b1;
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt == CNT_LAST) begin
                    mul_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle datapath; subtract-style ops share the adder as A + ~B + 1.
    always_comb begin
        add_sub   = (ALUControl == OP_SUB) || (ALUControl == OP_SLT) || (ALUControl == OP_SLTU);
        add_b     = add_sub ? ~BussB : BussB;
        add_sum   = {1'b0, BussA} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_sub};
        add_ovf   = (BussA[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != BussA[WIDTH-1]);
        shamt     = BussB[SW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (ALUControl)
            OP_NOR:  alu_res = ~(BussA | BussB);
            OP_SLT: begin
                alu_res   = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
                alu_carry = add_sum[WIDTH];
            end
            OP_ADD, OP_SUB: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_AND:  alu_res = BussA & BussB;
            OP_OR:   alu_res = BussA | BussB;
            OP_XOR:  alu_res = BussA ^ BussB;
            OP_SLTU: begin
                alu_res   = {{(WIDTH-1){1'b0}}, ~add_sum[WIDTH]};
                alu_carry = add_sum[WIDTH];
            end
            OP_SLL:  alu_res = BussA << shamt;
            OP_SRL:  alu_res = BussA >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(BussA) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Right-shifting shift-add: the upper half accumulates, the lower half
    // collects product bits as they retire.
    always_comb begin
        mul_addend = mul_b[0] ? mul_a : '0;
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        acc_next   = {mul_sum, acc[WIDTH-1:1]};
        mul_res    = mul_hi ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a  <= '0;
            mul_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
            mul_hi <= 1'b0;
        end else if (mul_start) begin
            mul_a  <= BussA;
            mul_b  <= BussB;
            acc    <= '0;
            cnt    <= '0;
            mul_hi <= (ALUControl == OP_MULHU);
        end else if (state == S_MUL) begin
            acc   <= acc_next;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // A completion wins over the consumer's clear of out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            Output    <= '0;
            CarryOut  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (accept && !is_mul_op) begin
            out_valid <= 1'b1;
            Output    <= alu_res;
            CarryOut  <= alu_carry;
            overflow  <= alu_ovf;
            zero      <= (alu_res == '0);
            negative  <= alu_res[WIDTH-1];
        end else if (mul_done) begin
            out_valid <= 1'b1;
            Output    <= mul_res;
            CarryOut  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= (mul_res == '0);
            negative  <= mul_res[WIDTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the combinational 32-bit ALU. It supports operand width WIDTH and widens the control code to 4 bits. The original NOR/SLT/ADD/SUB codes and the flag outputs are preserved, and it adds logic, unsigned-compare, shift and iterative multiply operations. Operands enter and results leave through valid/ready handshakes, so the block can sit in the EX stage of the pipelined CPU and stall the pipe during multiply.

## Interface
- WIDTH, 32, operand/result width; power of 2, ≥ 4.
- MUL_EN, 1, 1 enables MUL/MULHU; 0 makes those codes reserved.

- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- BussA  in  WIDTH  operand A.
- BussB  in  WIDTH  operand B; low log2(WIDTH) bits are the shift amount.
- ALUControl  in  4  operation code.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- Output  out  WIDTH  result.
- CarryOut, overflow, zero, negative  out  1 each  flags, registered with Output.
- busy  out  1  multiply in progress.

## Operation
- Op codes:
  - 0000 NOR
  - 0001 SLT (signed A<B → 1 else 0)
  - 0010 ADD
  - 0011 SUB (A−B)
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 SLTU
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - 1011 MUL (low WIDTH bits of unsigned A×B)
  - 1100 MULHU (high WIDTH bits)
  - 1101–1111 reserved
- Reserved ops, and MUL/MULHU when MUL_EN=0: Output=0, zero=1, all other flags 0.
- Adder is WIDTH+1 bits. SUB/SLT/SLTU compute A+~B+1.
- CarryOut: adder carry for ADD/SUB/SLT/SLTU (for SUB, 1 means A≥B unsigned); 0 for all other ops.
- overflow: signed overflow for ADD/SUB only; 0 otherwise.
- SLT result: sign of the difference XOR overflow.
- zero = (Output==0); negative = Output[WIDTH−1]; both apply to every op.
- Shifts use BussB[log2(WIDTH)−1:0]; upper bits are ignored.
- FSM states:
  - IDLE: accept when in_valid && in_ready.
    - Non-multiply op: load result/flags; out_valid←1; stay in IDLE.
    - MUL/MULHU: latch A, B and op; clear the 2·WIDTH accumulator and the counter; go to MUL.
  - MUL: one shift-add step per cycle. After step WIDTH, write the selected half and flags, set out_valid←1, go to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives one op per cycle under continuous out_ready.
- busy = (state==MUL).
- Result registers change only on a new completion. While out_valid && !out_ready, Output and all flags hold.
- out_valid clears on out_ready unless a new completion occurs in the same cycle. A completion has priority over the clear.

## Timing
- Reset values (while reset_n low): state IDLE, out_valid 0, Output 0, all flags 0, busy 0, counter 0.
- No accept while reset_n is low. Reset asserted mid-multiply aborts the operation and discards its result.
- Single-cycle ops: accepted at edge k → out_valid and result visible after edge k. Latency 1; throughput 1/cycle.
- MUL/MULHU: accepted at edge k → out_valid after edge k+WIDTH.
  - in_ready=0 after edge k through edge k+WIDTH.
  - With out_ready high at the completion, the next op is accepted at edge k+WIDTH+1.
- Multiply completion while the previous result is unconsumed cannot occur: a multiply is accepted only when the output slot frees in the same cycle.
- in_ready is combinational from state/out_valid/out_ready. No combinational path exists from in_valid to out_valid.

## Test plan
- **ADD overflow:** WIDTH=32, ADD 0x7FFFFFFF+0x00000001 → Output 0x80000000, overflow=1, negative=1, CarryOut=0, zero=0, out_valid one cycle after accept.
- **SUB and compares:**
  - SUB 5−5 → Output 0, zero=1, CarryOut=1.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU 0xFFFFFFFF vs 1 → 0.
  - SLT 0x80000000 vs 0x7FFFFFFF → 1.
- **Shifts and reserved ops:**
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLL 1 with BussB=33 → 0x00000002.
  - Reserved code 1111 → Output 0, zero=1.
- **Back-pressure:**
  - Issue ADD, SUB, AND, OR back-to-back with out_ready=1 → four results on four consecutive cycles.
  - Then hold out_ready=0 for 3 cycles → Output/flags stable, in_ready=0; the fifth op is accepted on the cycle out_ready returns.
- **Multiply:**
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 exactly 32 cycles after accept; busy=1 and in_ready=0 throughout.
  - MULHU on the same operands → 0xFFFFFFFE.
  - WIDTH=8: MUL 0xFF×0xFF → 0x01 after 8 cycles.
- **Reset mid-multiply:** pull reset_n low 10 cycles into a MUL → all outputs 0 immediately, no stale out_valid. A following ADD 2+3 returns 5 with latency 1.
